// File: rtl/rx_gearbox.sv
// rtl/rx_gearbox.sv - receive gearbox: 32-bit line words to 2-bit sync header plus two 32-bit payload words
// A slip pulse drops the oldest buffered bit and restarts framing at a header.
module rx_gearbox #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_WIDTH  = 66
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic                  i_slip,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_hdr,
  output logic                  o_data_valid,
  output logic                  o_hdr_valid
);

  localparam logic [6:0] DATA_LEN = 7'(DATA_WIDTH);
  localparam logic [6:0] HDR_LEN  = 7'(DATA_WIDTH + 2);
  localparam logic [6:0] CNT_MAX  = 7'(DATA_WIDTH + 1);

  typedef enum logic {HDR = 1'b0, DATA = 1'b1} phase_t;

  logic [BUF_WIDTH-1:0] bit_buf;
  logic [BUF_WIDTH-1:0] bit_buf_next;
  logic [BUF_WIDTH-1:0] work;
  logic [6:0]           cnt;
  logic [6:0]           cnt_next;
  logic [6:0]           avail;
  logic [6:0]           consumed;
  phase_t               phase;
  phase_t               phase_next;
  phase_t               ext_phase;
  logic                 hdr_fire;
  logic                 data_fire;

  // New bits land directly above the cnt bits already held; bits above avail are always zero.
  always_comb begin
    avail     = cnt + (i_data_valid ? DATA_LEN : 7'd0);
    work      = bit_buf;
    if (i_data_valid) begin
      work = bit_buf | ({{(BUF_WIDTH-DATA_WIDTH){1'b0}}, i_data} << cnt);
    end
    ext_phase = i_slip ? HDR : phase;
    if (i_slip && (avail != 7'd0)) begin
      work  = work >> 1;
      avail = avail - 7'd1;
    end
  end

  always_comb begin
    hdr_fire     = (ext_phase == HDR) && (avail >= HDR_LEN);
    data_fire    = (ext_phase == DATA) && (avail >= DATA_LEN);
    consumed     = hdr_fire ? HDR_LEN : (data_fire ? DATA_LEN : 7'd0);
    phase_next   = hdr_fire ? DATA : (data_fire ? HDR : ext_phase);
    bit_buf_next = work >> consumed;
    cnt_next     = avail - consumed;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      bit_buf <= '0;
      cnt     <= 7'd0;
      phase   <= HDR;
    end else begin
      bit_buf <= bit_buf_next;
      cnt     <= cnt_next;
      phase   <= phase_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_data       <= '0;
      o_hdr        <= 2'b00;
      o_data_valid <= 1'b0;
      o_hdr_valid  <= 1'b0;
    end else begin
      o_data_valid <= hdr_fire | data_fire;
      o_hdr_valid  <= hdr_fire;
      if (hdr_fire) begin
        o_hdr  <= work[1:0];
        o_data <= work[DATA_WIDTH+1:2];
      end else if (data_fire) begin
        o_data <= work[DATA_WIDTH-1:0];
      end
    end
  end

  // Each cycle adds at most 32 bits and consumes at least 32 once cnt reaches 32.
  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      assert (cnt <= CNT_MAX);
    end
  end

endmodule

// File: tb/tb_rx_gearbox.sv
// tb/tb_rx_gearbox.sv - directed self-checking bench for rx_gearbox
// Line stream: blocks of hdr=01 with payload words 32'hA000_0000+n, LSB first on the line.
module tb_rx_gearbox;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din = '0;
  logic        dv = 1'b0;
  logic        slip = 1'b0;
  logic [31:0] dout;
  logic [1:0]  hdr;
  logic        odv;
  logic        ohv;

  int compared = 0;
  int mismatched = 0;
  int wi = 0;
  int ok = 0;
  logic lb [40000];

  typedef struct {
    logic        v;
    logic        s;
    logic [31:0] d;
    logic        edv;
    logic        ehv;
    logic [1:0]  ehdr;
    logic [31:0] edata;
  } vec_t;
  vec_t tv[7];

  rx_gearbox dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_data      (din),
    .i_data_valid(dv),
    .i_slip      (slip),
    .o_data      (dout),
    .o_hdr       (hdr),
    .o_data_valid(odv),
    .o_hdr_valid (ohv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build_line(input int offset);
    logic [65:0] blk;
    for (int i = 0; i < 40000; i++) lb[i] = 1'b1;
    for (int j = 0; offset + 66 * (j + 1) <= 40000; j++) begin
      blk = {32'(32'hA000_0000 + 2 * j + 1), 32'(32'hA000_0000 + 2 * j), 2'b01};
      for (int b = 0; b < 66; b++) lb[offset + 66 * j + b] = blk[b];
    end
  endtask

  function automatic logic [31:0] line_word(input int w);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[b] = lb[32 * w + b];
    return r;
  endfunction

  task automatic step(input logic v, input logic s);
    dv   = v;
    slip = s;
    din  = v ? line_word(wi) : 32'h0;
    if (v) wi++;
    @(posedge clk);
    #1;
    dv   = 1'b0;
    slip = 1'b0;
  endtask

  task automatic sb_check(input string tag);
    if (odv) begin
      chk({tag, " hdr_valid"}, 32'(ohv), 32'((ok % 2) == 0));
      if ((ok % 2) == 0) chk({tag, " hdr"}, 32'(hdr), 32'd1);
      chk({tag, " data"}, dout, 32'(32'hA000_0000 + ok));
      ok++;
    end
  endtask

  task automatic run_aligned(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      step(1'b1, 1'b0);
      chk({tag, " cadence"}, 32'(odv), 32'((k % 33) != 0));
      sb_check(tag);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " o_data_valid"}, 32'(odv), 32'd0);
    chk({tag, " o_hdr_valid"}, 32'(ohv), 32'd0);
    chk({tag, " o_hdr"}, 32'(hdr), 32'd0);
    chk({tag, " o_data"}, dout, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int gap_out;
    int hc;
    int locked;
    int n;
    logic [31:0] cd [16];
    logic        ch [16];
    logic [1:0]  chh [16];

    // block {w1=9ABCDEF0, w0=12345678, hdr=10}, then slip and hand-built words
    tv[0] = '{1'b1, 1'b0, 32'h48D1_59E2, 1'b0, 1'b0, 2'b00, 32'h0000_0000};
    tv[1] = '{1'b1, 1'b0, 32'h6AF3_7BC0, 1'b1, 1'b1, 2'b10, 32'h1234_5678};
    tv[2] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 2'b00, 32'h1234_5678};
    tv[3] = '{1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 2'b00, 32'h9ABC_DEF0};
    tv[4] = '{1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 2'b00, 32'h9ABC_DEF0};
    tv[5] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 2'b00, 32'hF800_0000};
    tv[6] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 2'b00, 32'h07FF_FFFF};

    do_reset();
    chk_zero("reset");

    for (int i = 0; i < 7; i++) begin
      dv   = tv[i].v;
      slip = tv[i].s;
      din  = tv[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d data_valid", i), 32'(odv), 32'(tv[i].edv));
      chk($sformatf("vec%0d hdr_valid", i), 32'(ohv), 32'(tv[i].ehv));
      chk($sformatf("vec%0d data", i), dout, tv[i].edata);
      if (tv[i].ehv) chk($sformatf("vec%0d hdr", i), 32'(hdr), 32'(tv[i].ehdr));
    end
    dv   = 1'b0;
    slip = 1'b0;

    // slip on an empty buffer, then aligned stream with a 5-cycle gap
    do_reset();
    step(1'b0, 1'b1);
    chk("idle slip data_valid", 32'(odv), 32'd0);
    chk("idle slip hdr_valid", 32'(ohv), 32'd0);
    build_line(0);
    wi = 0;
    ok = 0;
    run_aligned(66, "aligned");
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0);
      sb_check("pre gap");
    end
    gap_out = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0);
      if (odv) gap_out++;
      sb_check("gap");
    end
    chk("gap outputs at most one", 32'(gap_out <= 1), 32'd1);
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0);
      sb_check("post gap");
    end
    chk("post gap word count", 32'(ok), 32'd112);

    // one-cycle reset mid-block
    rst_n = 1'b0;
    step(1'b1, 1'b0);
    rst_n = 1'b1;
    chk_zero("mid reset");
    wi = 0;
    ok = 0;
    run_aligned(34, "restart");

    // one extra line bit: misaligned headers read as 11 until a slip at a frame start
    do_reset();
    build_line(1);
    wi = 0;
    ok = 0;
    hc = 0;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b0);
      if (ohv) begin
        chk("misaligned hdr", 32'(hdr), 32'd3);
        hc++;
      end
    end
    for (int k = 0; k < 4 && !(odv && !ohv); k++) step(1'b1, 1'b0);
    chk("slip wait for data word", 32'(odv && !ohv), 32'd1);
    step(1'b1, 1'b1);
    ok = 2 * hc;
    sb_check("after slip");
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0);
      sb_check("after slip");
    end
    chk("after slip progress", 32'(ok >= 2 * hc + 30), 32'd1);

    // 66 back-to-back slips, then single slips until framing locks again
    do_reset();
    build_line(0);
    wi = 0;
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0);
    for (int k = 0; k < 66; k++) step(1'b1, 1'b1);
    locked = 0;
    for (int a = 0; a < 70 && locked == 0; a++) begin
      n = 0;
      for (int k = 0; k < 8; k++) begin
        step(1'b1, 1'b0);
        if (odv) begin
          cd[n]  = dout;
          ch[n]  = ohv;
          chh[n] = hdr;
          n++;
        end
      end
      for (int i = 0; i + 3 < n && locked == 0; i++) begin
        if (ch[i] && chh[i] == 2'b01 && !ch[i+1] && ch[i+2] && chh[i+2] == 2'b01 && !ch[i+3] &&
            cd[i][31:28] == 4'hA && cd[i][0] == 1'b0 && cd[i+1] == cd[i] + 32'd1 &&
            cd[i+2] == cd[i] + 32'd2 && cd[i+3] == cd[i] + 32'd3) begin
          locked = 1;
          ok = int'(cd[i] - 32'hA000_0000) + (n - i);
        end
      end
      if (locked == 0) begin
        for (int k = 0; k < 4 && !(odv && !ohv); k++) step(1'b1, 1'b0);
        chk("hunt wait for data word", 32'(odv && !ohv), 32'd1);
        step(1'b1, 1'b1);
      end
    end
    chk("relock after slip hunt", 32'(locked), 32'd1);
    if (locked != 0) begin
      for (int k = 0; k < 20; k++) begin
        step(1'b1, 1'b0);
        sb_check("relocked");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
